// File: rtl/regfile_writeback.sv
// Writeback sequencer for the multicycle core: picks the result source by opcode,
// waits for load data under a timeout, and issues one register-file write per instruction.
module regfile_writeback #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [31:0] instr,
  input  logic [31:0] alu_result,
  input  logic [31:0] pc_plus4,
  input  logic        mem_valid,
  input  logic [31:0] mem_rdata,
  output logic        write_en_3,
  output logic [4:0]  write_addr_3,
  output logic [31:0] write_data_3,
  output logic        wb_done,
  output logic        load_fault
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    WRITE     = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [REG_W-1:0]    rd_q, rd_d;
  logic [2:0]          fn3_q, fn3_d;
  logic [1:0]          off_q, off_d;
  logic                ready_d, wen_d, done_d, fault_d;
  logic [REG_W-1:0]    waddr_d;
  logic [DATA_W-1:0]   wdata_d;

  logic [6:0]          opcode;
  logic [REG_W-1:0]    rd_in;
  logic [2:0]          fn3_in;
  logic [1:0]          off_in;
  logic                load_ok;
  logic [7:0]          lane_b;
  logic [15:0]         lane_h;
  logic [DATA_W-1:0]   load_val;
  logic                unused_instr;

  assign opcode       = instr[6:0];
  assign rd_in        = instr[11:7];
  assign fn3_in       = instr[14:12];
  assign off_in       = alu_result[1:0];
  assign unused_instr = ^instr[31:15];

  // Legal load widths and their natural alignment
  always_comb begin
    load_ok = 1'b0;
    case (fn3_in)
      3'b000, 3'b100: load_ok = 1'b1;
      3'b001, 3'b101: load_ok = ~off_in[0];
      3'b010:         load_ok = (off_in == 2'b00);
      default:        load_ok = 1'b0;
    endcase
  end

  // Lane extraction and extension from the latched offset and funct3
  always_comb begin
    lane_b = mem_rdata[{off_q, 3'b000} +: 8];
    lane_h = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (fn3_q)
      3'b000:  load_val = {{24{lane_b[7]}}, lane_b};
      3'b001:  load_val = {{16{lane_h[15]}}, lane_h};
      3'b100:  load_val = {24'd0, lane_b};
      3'b101:  load_val = {16'd0, lane_h};
      default: load_val = mem_rdata;
    endcase
  end

  // Next state and next registered outputs; WRITE outputs are loaded on entry
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    fn3_d   = fn3_q;
    off_d   = off_q;
    wen_d   = 1'b0;
    waddr_d = '0;
    wdata_d = '0;
    done_d  = 1'b0;
    fault_d = 1'b0;
    cnt_inc = CNT_W'(cnt_q + CNT_W'(1));

    case (state_q)
      IDLE: begin
        if (wb_valid) begin
          rd_d  = rd_in;
          fn3_d = fn3_in;
          off_d = off_in;
          case (opcode)
            OP_REG, OP_IMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: begin
              if (rd_in != '0) begin
                state_d = WRITE;
                wen_d   = 1'b1;
                waddr_d = rd_in;
                wdata_d = (opcode == OP_JAL || opcode == OP_JALR) ? pc_plus4 : alu_result;
              end
              done_d = 1'b1;
            end
            OP_LOAD: begin
              if (load_ok) begin
                cnt_d   = '0;
                state_d = LOAD_WAIT;
              end else begin
                fault_d = 1'b1;
                done_d  = 1'b1;
              end
            end
            default: done_d = 1'b1;
          endcase
        end
      end
      LOAD_WAIT: begin
        if (mem_valid) begin
          done_d  = 1'b1;
          state_d = IDLE;
          if (rd_q != '0) begin
            state_d = WRITE;
            wen_d   = 1'b1;
            waddr_d = rd_q;
            wdata_d = load_val;
          end
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_W'(TIMEOUT)) begin
            fault_d = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rd_q         <= '0;
      fn3_q        <= '0;
      off_q        <= '0;
      wb_ready     <= 1'b1;
      write_en_3   <= 1'b0;
      write_addr_3 <= '0;
      write_data_3 <= '0;
      wb_done      <= 1'b0;
      load_fault   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rd_q         <= rd_d;
      fn3_q        <= fn3_d;
      off_q        <= off_d;
      wb_ready     <= ready_d;
      write_en_3   <= wen_d;
      write_addr_3 <= waddr_d;
      write_data_3 <= wdata_d;
      wb_done      <= done_d;
      load_fault   <= fault_d;
    end
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// Scoreboard bench for regfile_writeback: driver pushes expected retirements from a
// reference model, a monitor pops and compares them whenever the DUT retires.
module tb_regfile_writeback;

  localparam int unsigned T = 4;
  localparam logic [6:0] LOAD = 7'b0000011;

  logic        clk;
  logic        reset_n;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] instr;
  logic [31:0] alu_result;
  logic [31:0] pc_plus4;
  logic        mem_valid;
  logic [31:0] mem_rdata;
  logic        write_en_3;
  logic [4:0]  write_addr_3;
  logic [31:0] write_data_3;
  logic        wb_done;
  logic        load_fault;

  regfile_writeback #(.TIMEOUT(T)) dut (
    .clk(clk), .reset_n(reset_n), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .instr(instr), .alu_result(alu_result), .pc_plus4(pc_plus4),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata),
    .write_en_3(write_en_3), .write_addr_3(write_addr_3), .write_data_3(write_data_3),
    .wb_done(wb_done), .load_fault(load_fault)
  );

  typedef struct {
    logic        wen;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        fault;
    int unsigned cyc;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Monitor: every retirement is matched against the oldest expectation
  exp_t m;
  always @(negedge clk) begin
    if (wb_done === 1'b1 || write_en_3 === 1'b1 || load_fault === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_retire: got done=%b wen=%b fault=%b at cycle %0d, required no activity",
                 wb_done, write_en_3, load_fault, cyc);
      end else begin
        m = q.pop_front();
        if (!(wb_done === 1'b1 && write_en_3 === m.wen && load_fault === m.fault && cyc == m.cyc &&
              (!m.wen || (write_addr_3 === m.addr && write_data_3 === m.data)))) begin
          errors++;
          $display("FAIL retire: got wen=%b addr=%0d data=%h fault=%b done=%b cyc=%0d, required wen=%b addr=%0d data=%h fault=%b done=1 cyc=%0d",
                   write_en_3, write_addr_3, write_data_3, load_fault, wb_done, cyc,
                   m.wen, m.addr, m.data, m.fault, m.cyc);
        end
      end
    end
  end

  // Reference model: what retires, and on which cycle, for an instruction accepted at edge a
  task automatic model(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] pc, input logic [31:0] rdata,
                       input int unsigned k, input int unsigned a, output exp_t e, output bit waits);
    int unsigned off, size;
    bit legal;
    logic [31:0] v;
    e = '{1'b0, 5'd0, 32'd0, 1'b0, a};
    waits = 1'b0;
    off  = alu % 4;
    if (op inside {7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111}) begin
      if (rd != 0) begin
        e.wen  = 1'b1;
        e.addr = rd;
        e.data = (op inside {7'b1101111, 7'b1100111}) ? pc : alu;
      end
    end else if (op == LOAD) begin
      legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      size  = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
      if (!legal || (off % size) != 0) begin
        e.fault = 1'b1;
      end else begin
        waits = 1'b1;
        if (k >= T) begin
          e.fault = 1'b1;
          e.cyc   = a + T;
        end else begin
          e.cyc = a + k + 1;
          if (rd != 0) begin
            v = rdata >> (8 * off);
            if (size == 1) begin
              v = v % 256;
              if (f3 < 4 && v >= 128) v = v - 32'd256;
            end else if (size == 2) begin
              v = v % 65536;
              if (f3 < 4 && v >= 32768) v = v - 32'd65536;
            end
            e.wen  = 1'b1;
            e.addr = rd;
            e.data = v;
          end
        end
      end
    end
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 64 && wb_ready !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    check("ready_before_issue", 32'(wb_ready), 32'd1);
  endtask

  // Driver: k = LOAD_WAIT cycles without mem_valid before it is raised
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] pc, input logic [31:0] rdata,
                       input int unsigned k);
    exp_t e;
    bit waits;
    logic [31:0] ins;
    wait_ready();
    ins = $urandom;
    ins[6:0]   = op;
    ins[11:7]  = rd;
    ins[14:12] = f3;
    model(op, f3, rd, alu, pc, rdata, k, cyc + 1, e, waits);
    q.push_back(e);
    wb_valid   = 1'b1;
    instr      = ins;
    alu_result = alu;
    pc_plus4   = pc;
    mem_valid  = 1'($urandom % 2);
    mem_rdata  = $urandom;
    @(posedge clk); #1;
    wb_valid   = 1'b0;
    instr      = $urandom;
    alu_result = $urandom;
    pc_plus4   = $urandom;
    mem_valid  = 1'b0;
    check("ready_after_accept", 32'(wb_ready), (waits || e.wen) ? 32'd0 : 32'd1);
    if (waits) begin
      for (int i = 0; i < int'(k) && i < int'(T); i++) begin
        mem_rdata = $urandom;
        @(posedge clk); #1;
      end
      if (k < T) begin
        mem_valid = 1'b1;
        mem_rdata = rdata;
        @(posedge clk); #1;
        mem_valid = 1'b0;
        mem_rdata = $urandom;
      end
    end else if (e.wen) begin
      @(posedge clk); #1;
      check("ready_after_write", 32'(wb_ready), 32'd1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wb_ready"},   32'(wb_ready),     32'd1);
    check({tag, "_write_en"},   32'(write_en_3),   32'd0);
    check({tag, "_write_addr"}, 32'(write_addr_3), 32'd0);
    check({tag, "_write_data"}, write_data_3,      32'd0);
    check({tag, "_wb_done"},    32'(wb_done),      32'd0);
    check({tag, "_load_fault"}, 32'(load_fault),   32'd0);
  endtask

  logic [6:0] ops [10] = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111,
                           7'b1100111, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1110011};

  initial begin
    reset_n = 1'b0; wb_valid = 1'b0; instr = '0; alu_result = '0; pc_plus4 = '0;
    mem_valid = 1'b0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset_n = 1'b1;
    @(posedge clk); #1;

    issue(7'b0110011, 3'b000, 5'd5, 32'h0000_1234, 32'h0, 32'h0, 0);
    issue(LOAD, 3'b000, 5'd3, 32'h0000_0002, 32'h0, 32'h0080_0000, 3);
    issue(LOAD, 3'b100, 5'd3, 32'h0000_0002, 32'h0, 32'h0080_0000, 3);
    issue(LOAD, 3'b001, 5'd4, 32'h0000_0001, 32'h0, 32'h0, 0);
    issue(LOAD, 3'b011, 5'd4, 32'h0000_0000, 32'h0, 32'h0, 0);
    issue(LOAD, 3'b010, 5'd6, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, T);
    issue(LOAD, 3'b010, 5'd6, 32'h0000_0040, 32'h0, 32'hCAFE_F00D, T - 1);
    issue(LOAD, 3'b101, 5'd9, 32'h0000_0002, 32'h0, 32'h8001_7FFF, 0);
    issue(LOAD, 3'b001, 5'd9, 32'h0000_0002, 32'h0, 32'h8001_7FFF, 1);
    issue(LOAD, 3'b000, 5'd0, 32'h0000_0000, 32'h0, 32'h1234_5678, 1);
    issue(7'b1101111, 3'b000, 5'd1, 32'h5555_0000, 32'h0000_0104, 32'h0, 0);
    issue(7'b0010011, 3'b000, 5'd0, 32'h0000_0077, 32'h0, 32'h0, 0);
    issue(7'b0100011, 3'b010, 5'd5, 32'h0000_0100, 32'h0, 32'h0, 0);

    // Reset during LOAD_WAIT must abort without a write
    wait_ready();
    wb_valid = 1'b1; instr = 32'h0000_2383; alu_result = 32'h100;
    @(posedge clk); #1;
    wb_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    reset_n = 1'b0;
    #1;
    mem_valid = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    #1;
    check_reset_outputs("mid_reset");
    repeat (2) begin @(posedge clk); #1; end
    check_reset_outputs("held_reset");
    mem_valid = 1'b0;
    reset_n = 1'b1;
    @(posedge clk); #1;
    issue(7'b0110011, 3'b000, 5'd12, 32'h0BAD_F00D, 32'h0, 32'h0, 0);

    for (int n = 0; n < 250; n++) begin
      logic [6:0] op;
      logic [4:0] rd;
      op = ops[$urandom_range(0, 9)];
      if ($urandom_range(0, 9) == 0) op = 7'($urandom);
      if ($urandom_range(0, 2) == 0) op = LOAD;
      rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      issue(op, 3'($urandom), rd, $urandom, $urandom, $urandom, $urandom_range(0, T + 1));
    end

    for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
    #1;
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Writeback sequencer for the multicycle RISC-V core; it drives the write port of the register file. It accepts a completed instruction from the execute/memory side over a valid/ready handshake and selects the result source from the opcode: ALU result, extended load data, or PC+4. It then issues exactly one single-cycle register-file write, with x0 and non-writing instructions suppressed. Load data waits for a memory-valid strobe under a timeout counter.

## Interface
- `TIMEOUT`, default 16: maximum number of cycles spent in LOAD_WAIT before aborting; legal range 1..255.
- `clk` in 1: system clock; all state changes on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `wb_valid` in 1: instruction, result and PC+4 inputs are valid.
- `wb_ready` out 1: the block can accept an instruction; high only in IDLE.
- `instr` in 32: instruction word being retired; only opcode [6:0], rd [11:7] and funct3 [14:12] are used.
- `alu_result` in 32: ALU output; for loads, the byte address, with [1:0] used as the byte offset.
- `pc_plus4` in 32: link value for JAL/JALR.
- `mem_valid` in 1: `mem_rdata` is valid this cycle.
- `mem_rdata` in 32: aligned 32-bit word read from memory.
- `write_en_3` out 1: register-file write enable.
- `write_addr_3` out 5: destination register rd.
- `write_data_3` out 32: data to write.
- `wb_done` out 1: one-cycle pulse when an instruction retires, whether or not it writes.
- `load_fault` out 1: one-cycle pulse on a misaligned load, an illegal load funct3, or a timeout.

## Operation
- States: IDLE, LOAD_WAIT, WRITE.
- IDLE: `wb_ready` is 1. On `wb_valid && wb_ready`, latch rd, funct3 and `pc_plus4`; latch `alu_result` both as the data and as the byte offset. Then classify by opcode:
  - Opcodes 0110011, 0010011, 0110111, 0010111 (ALU): the source is `alu_result`. Go to WRITE.
  - Opcodes 1101111, 1100111 (JAL/JALR): the source is `pc_plus4`. Go to WRITE.
  - Opcode 0000011 (LOAD): check alignment and funct3 first (see the checks below). If both pass, clear the timeout counter and go to LOAD_WAIT.
  - Any other opcode (store, branch, system, unknown): no write. Pulse `wb_done` and stay in IDLE.
  - If the captured rd is 0 on any writing opcode, the instruction is treated as non-writing. Exception: loads still go through LOAD_WAIT so that the memory strobe is consumed, but they never write.
- Load checks:
  - funct3 must be in {000, 001, 010, 100, 101}.
  - Halfword loads (001, 101) need offset[0]=0. Word loads (010) need offset=00.
  - On failure: pulse `load_fault` and `wb_done`, perform no write, stay in IDLE.
- LOAD_WAIT:
  - If `mem_valid`=1: extract the lane (byte at offset×8, or halfword at offset[1]×16) and extend it. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word. Latch the result and go to WRITE. If rd is 0, go to IDLE with a `wb_done` pulse instead.
  - Otherwise increment the counter. On reaching TIMEOUT, pulse `load_fault` and `wb_done`, perform no write, go to IDLE.
- WRITE: `write_en_3`=1 for exactly this cycle, with `write_addr_3`=rd and `write_data_3`=the latched value. `wb_done`=1. Next state is IDLE.
- All outputs are registered or decoded from registered state. `write_en_3` is never high outside WRITE.

## Timing
- Reset (asynchronous, `reset_n`=0): state is IDLE, the counter is 0, and all latches are 0. Output values during reset:
  - `wb_ready`=1
  - `write_en_3`=0, `write_addr_3`=0, `write_data_3`=0
  - `wb_done`=0, `load_fault`=0
- Reset asserted mid-operation (LOAD_WAIT or WRITE) aborts immediately; no write occurs.
- ALU and jump instructions: accepted at edge N; WRITE occupies cycle N+1; `wb_ready` is back to 1 in cycle N+2. Throughput is one instruction per 2 cycles.
- Loads:
  - `mem_valid` in the acceptance cycle is ignored; it is sampled only in LOAD_WAIT.
  - If `mem_valid` is first sampled high at edge M, `write_en_3` is high in cycle M+1.
  - `mem_valid` arriving in the same cycle the counter reaches TIMEOUT wins: the data is written and there is no fault.
- Non-writing and faulting instructions: `wb_done` (and `load_fault` if applicable) pulses in the cycle after acceptance, and `wb_ready` stays 1.
- `mem_valid` outside LOAD_WAIT is ignored.

## Test plan
- ADD with rd=5 and `alu_result`=0x0000_1234, accepted at cycle 0 -> cycle 1: `write_en_3`=1, addr=5, data=0x0000_1234, `wb_done`=1; cycle 2: `wb_ready`=1.
- LB with rd=3, offset=2, and `mem_valid` after 3 wait cycles with `mem_rdata`=0x0080_0000 -> data=0xFFFF_FF80. The same stimulus as LBU -> data=0x0000_0080.
- LH with offset=1 -> `load_fault` and `wb_done` pulse in cycle 1, no write, `wb_ready` stays 1. Repeat with funct3=011: same response.
- LW with TIMEOUT=4 and `mem_valid` never asserted -> `load_fault`=1 and `wb_done`=1 after 4 LOAD_WAIT cycles, no write. Then `mem_valid` asserted at exactly the 4th cycle -> write occurs, no fault.
- JAL with rd=1 and `pc_plus4`=0x104 -> write addr=1, data=0x104. ADDI with rd=0 -> `wb_done` only, `write_en_3` stays 0. SW -> `wb_done` only.
- Assert `reset_n` low during LOAD_WAIT, then raise `mem_valid` -> no write; all outputs at reset values; next ADD completes normally.
